// File: rtl/sobel_frame_arbiter.sv
// sobel_frame_arbiter: round-robin, frame-granular sharing of one sobel engine between two gray pixel streams
// Ports: i_clock/i_reset (sync, active-high);
//        i_in{0,1}_empty, i_in{0,1}_dout, o_in{0,1}_rd_en : requester gray FIFOs;
//        i_out{0,1}_full, o_out{0,1}_wr_en, o_out{0,1}_din : requester output FIFOs;
//        o_eng_reset, i_eng_gray_rd_en, o_eng_gray_empty, o_eng_gray_dout,
//        i_eng_wr_en, i_eng_din, o_eng_full, i_eng_done     : engine side;
//        o_grant_id, o_frame_done, o_abort                  : status.
module sobel_frame_arbiter #(
    parameter int IMG_HEIGHT = 540,
    parameter int IMG_WIDTH  = 720,
    parameter int TIMEOUT    = 4096
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_in0_empty,
    input  logic       i_in1_empty,
    input  logic [7:0] i_in0_dout,
    input  logic [7:0] i_in1_dout,
    output logic       o_in0_rd_en,
    output logic       o_in1_rd_en,
    input  logic       i_out0_full,
    input  logic       i_out1_full,
    output logic       o_out0_wr_en,
    output logic       o_out1_wr_en,
    output logic [7:0] o_out0_din,
    output logic [7:0] o_out1_din,
    output logic       o_eng_reset,
    input  logic       i_eng_gray_rd_en,
    output logic       o_eng_gray_empty,
    output logic [7:0] o_eng_gray_dout,
    input  logic       i_eng_wr_en,
    input  logic [7:0] i_eng_din,
    output logic       o_eng_full,
    input  logic       i_eng_done,
    output logic       o_grant_id,
    output logic       o_frame_done,
    output logic       o_abort
);
    localparam int FRAME_PIXELS = IMG_HEIGHT * IMG_WIDTH;
    localparam int CW = $clog2(FRAME_PIXELS + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FP = CW'(FRAME_PIXELS);
    localparam logic [WW-1:0] WLIM = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE, ABORT} state_t;

    state_t        r_state, w_next;
    logic          r_grant, w_grant_next;
    logic [CW-1:0] r_in_cnt, r_out_cnt;
    logic [WW-1:0] r_wdog;
    logic          w_run, w_drain, w_g_empty, w_g_full, w_in_sat, w_out_sat, w_rd, w_wr;

    assign w_run     = r_state == RUN;
    assign w_drain   = r_state == DRAIN;
    assign w_g_empty = r_grant ? i_in1_empty : i_in0_empty;
    assign w_g_full  = r_grant ? i_out1_full : i_out0_full;
    assign w_in_sat  = r_in_cnt == FP;
    assign w_out_sat = r_out_cnt == FP;

    // Outside RUN the engine is fully stalled; saturated counters block any extra pixel.
    assign o_eng_gray_empty = !w_run | w_g_empty | w_in_sat;
    assign o_eng_full       = !w_run | w_g_full | w_out_sat;
    assign o_eng_gray_dout  = r_grant ? i_in1_dout : i_in0_dout;

    // In DRAIN the arbiter itself pulls the leftover input pixels of the frame and discards them.
    assign w_rd = w_run ? i_eng_gray_rd_en & !o_eng_gray_empty : w_drain & !w_g_empty & !w_in_sat;
    assign w_wr = i_eng_wr_en & !o_eng_full;

    assign o_in0_rd_en  = w_rd & !r_grant;
    assign o_in1_rd_en  = w_rd & r_grant;
    assign o_out0_wr_en = w_wr & !r_grant;
    assign o_out1_wr_en = w_wr & r_grant;
    assign o_out0_din   = i_eng_din;
    assign o_out1_din   = i_eng_din;

    assign o_eng_reset  = i_reset | r_state == CLEAR | r_state == ABORT;
    assign o_grant_id   = r_grant;
    assign o_frame_done = r_state == DONE;
    assign o_abort      = r_state == ABORT;

    always_comb begin
        w_next       = r_state;
        w_grant_next = r_grant;
        case (r_state)
            IDLE: if (!i_in0_empty || !i_in1_empty) begin
                // Both waiting: alternate away from the last owner; otherwise take the only one.
                w_grant_next = (!i_in0_empty && !i_in1_empty) ? !r_grant : i_in0_empty;
                w_next       = CLEAR;
            end
            CLEAR: w_next = RUN;
            RUN: w_next = (i_eng_done || w_out_sat) ? DRAIN : (r_wdog == WLIM) ? ABORT : RUN;
            DRAIN: w_next = w_in_sat ? DONE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_grant   <= 1'b1;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_wdog    <= '0;
        end else begin
            r_state <= w_next;
            r_grant <= w_grant_next;
            if (r_state == CLEAR) begin
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
                r_wdog    <= '0;
            end else begin
                if (w_rd) r_in_cnt <= r_in_cnt + 1'b1;
                if (w_wr) r_out_cnt <= r_out_cnt + 1'b1;
                if (w_run) r_wdog <= (w_rd | w_wr) ? '0 : r_wdog + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sobel_frame_arbiter.sv
// tb_sobel_frame_arbiter: randomized self-checking bench with FIFO, engine and arbitration reference models
module tb_sobel_frame_arbiter;
    localparam int H = 4, W = 4, FP = H * W, TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in0_empty, in1_empty, in0_rd, in1_rd;
    logic [7:0] in0_dout, in1_dout;
    logic       out0_full = 1'b0, out1_full = 1'b0, out0_wr, out1_wr;
    logic [7:0] out0_din, out1_din;
    logic       eng_reset, eng_rd_en, eng_empty, eng_wr_en, eng_full, eng_done;
    logic [7:0] eng_dout, eng_din;
    logic       grant, fdone, abrt;

    sobel_frame_arbiter #(.IMG_HEIGHT(H), .IMG_WIDTH(W), .TIMEOUT(TO)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_in0_empty(in0_empty), .i_in1_empty(in1_empty),
        .i_in0_dout(in0_dout), .i_in1_dout(in1_dout),
        .o_in0_rd_en(in0_rd), .o_in1_rd_en(in1_rd),
        .i_out0_full(out0_full), .i_out1_full(out1_full),
        .o_out0_wr_en(out0_wr), .o_out1_wr_en(out1_wr),
        .o_out0_din(out0_din), .o_out1_din(out1_din),
        .o_eng_reset(eng_reset), .i_eng_gray_rd_en(eng_rd_en),
        .o_eng_gray_empty(eng_empty), .o_eng_gray_dout(eng_dout),
        .i_eng_wr_en(eng_wr_en), .i_eng_din(eng_din), .o_eng_full(eng_full),
        .i_eng_done(eng_done), .o_grant_id(grant), .o_frame_done(fdone), .o_abort(abrt)
    );

    logic [7:0] q_in0[$], q_in1[$], q_out0[$], q_out1[$], e_pend[$], exp0[$], exp1[$];
    logic       g_seq[$], exp_g[$];
    int e_rd, e_wr, e_target;
    bit e_extra;
    int n_cmp = 0, n_err = 0;
    int n_fd, n_ab, n_er, viol, pop0, pop1, cyc, last_hs, ab_cyc;

    function automatic int qdiff(input logic [7:0] a[$], input logic [7:0] b[$]);
        int d = (a.size() == b.size()) ? 0 : 1;
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) d++;
        return d;
    endfunction

    task automatic refresh();
        in0_empty = q_in0.size() == 0;
        in1_empty = q_in1.size() == 0;
        in0_dout  = in0_empty ? 8'h00 : q_in0[0];
        in1_dout  = in1_empty ? 8'h00 : q_in1[0];
        eng_rd_en = e_extra || (e_rd < e_target && e_pend.size() < 4);
        eng_wr_en = e_pend.size() > 0 || (e_extra && e_wr >= FP);
        eng_din   = e_pend.size() > 0 ? e_pend[0] : 8'hEE;
        eng_done  = !e_extra && e_rd >= e_target && e_pend.size() == 0;
    endtask

    task automatic clear_model();
        q_in0.delete(); q_in1.delete(); q_out0.delete(); q_out1.delete();
        e_pend.delete(); exp0.delete(); exp1.delete(); g_seq.delete(); exp_g.delete();
        e_rd = 0; e_wr = 0; e_target = FP; e_extra = 0;
        n_fd = 0; n_ab = 0; n_er = 0; viol = 0; pop0 = 0; pop1 = 0; last_hs = 0; ab_cyc = 0;
        out0_full = 0; out1_full = 0;
        refresh();
    endtask

    task automatic load(input int which, input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (which == 0) begin q_in0.push_back(b); exp0.push_back(b + 8'd1); end
            else begin q_in1.push_back(b); exp1.push_back(b + 8'd1); end
        end
        refresh();
    endtask

    task automatic step();
        logic s_rd0, s_rd1, s_wr0, s_wr1, s_erd, s_ewr, s_er;
        logic [7:0] s_d0, s_d1, s_ed;
        @(negedge clk);
        s_rd0 = in0_rd; s_rd1 = in1_rd; s_wr0 = out0_wr; s_wr1 = out1_wr;
        s_d0 = out0_din; s_d1 = out1_din; s_ed = eng_dout;
        s_erd = eng_rd_en && !eng_empty;
        s_ewr = eng_wr_en && !eng_full;
        s_er = eng_reset;
        if ((s_rd0 && in0_empty) || (s_rd1 && in1_empty) || (s_wr0 && out0_full) || (s_wr1 && out1_full) ||
            (s_rd0 && s_rd1) || (s_wr0 && s_wr1) || (abrt && !eng_reset)) viol++;
        if (fdone) begin n_fd++; g_seq.push_back(grant); end
        if (abrt) begin n_ab++; ab_cyc = cyc; end
        if (eng_reset && !rst) n_er++;
        if (s_rd0 || s_rd1 || s_wr0 || s_wr1) last_hs = cyc;
        @(posedge clk);
        #1;
        cyc++;
        if (s_rd0 && q_in0.size() > 0) begin void'(q_in0.pop_front()); pop0++; end
        if (s_rd1 && q_in1.size() > 0) begin void'(q_in1.pop_front()); pop1++; end
        if (s_wr0) q_out0.push_back(s_d0);
        if (s_wr1) q_out1.push_back(s_d1);
        if (s_er) begin
            e_rd = 0; e_wr = 0; e_pend.delete();
        end else begin
            if (s_ewr && e_pend.size() > 0) begin void'(e_pend.pop_front()); e_wr++; end
            if (s_erd) begin e_pend.push_back(s_ed + 8'd1); e_rd++; end
        end
        refresh();
    endtask

    task automatic do_reset();
        rst = 1; step(); step();
        clear_model();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_model();
        load(0, 3);
        step(); step();
        n_cmp++;
        if ({grant, fdone, abrt, eng_reset, eng_empty, eng_full, in0_rd, in1_rd, out0_wr, out1_wr} !== 10'b1001110000) begin
            n_err++;
            $display("FAIL reset_outputs got %b want 1001110000",
                     {grant, fdone, abrt, eng_reset, eng_empty, eng_full, in0_rd, in1_rd, out0_wr, out1_wr});
        end
        clear_model();
        rst = 0;
        step();
        n_cmp++;
        if ({eng_reset, grant, eng_empty, eng_full} !== 4'b0111) begin
            n_err++; $display("FAIL reset_release_idle got %b want 0111", {eng_reset, grant, eng_empty, eng_full});
        end
    endtask

    task automatic test_single();
        clear_model();
        load(0, FP);
        for (int i = 0; i < 200 && n_fd == 0; i++) step();
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (n_fd !== 1) begin n_err++; $display("FAIL single_frame_done got %0d want 1", n_fd); end
        n_cmp++; if (g_seq.size() != 1 || g_seq[0] !== 1'b0) begin n_err++; $display("FAIL single_grant got size %0d want grant 0", g_seq.size()); end
        n_cmp++; if (n_er !== 1) begin n_err++; $display("FAIL single_eng_reset_cycles got %0d want 1", n_er); end
        n_cmp++; if (pop0 !== FP) begin n_err++; $display("FAIL single_reads got %0d want %0d", pop0, FP); end
        n_cmp++; if (qdiff(q_out0, exp0) != 0) begin n_err++; $display("FAIL single_out0_data got %0d px (%0d diffs) want %0d px", q_out0.size(), qdiff(q_out0, exp0), exp0.size()); end
        n_cmp++; if (q_out1.size() !== 0) begin n_err++; $display("FAIL single_out1_untouched got %0d writes want 0", q_out1.size()); end
        n_cmp++; if (viol !== 0 || n_ab !== 0) begin n_err++; $display("FAIL single_protocol got viol=%0d abort=%0d want 0/0", viol, n_ab); end
    endtask

    task automatic test_back_to_back();
        int a0 = 2, a1 = 2;
        logic last = 1'b1, g;
        bit pf0 = 0, pf1 = 0;
        do_reset();
        load(0, 2 * FP);
        load(1, 2 * FP);
        while (a0 > 0 || a1 > 0) begin
            g = (a0 > 0 && a1 > 0) ? !last : (a0 > 0 ? 1'b0 : 1'b1);
            exp_g.push_back(g);
            if (g) a1--; else a0--;
            last = g;
        end
        for (int i = 0; i < 1000 && n_fd < 4; i++) begin
            out0_full = !pf0 && $urandom_range(0, 3) == 0;
            out1_full = !pf1 && $urandom_range(0, 3) == 0;
            pf0 = out0_full; pf1 = out1_full;
            step();
        end
        out0_full = 0; out1_full = 0;
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (n_fd !== 4) begin n_err++; $display("FAIL b2b_frame_done got %0d want 4", n_fd); end
        n_cmp++;
        if (g_seq.size() != exp_g.size() || g_seq != exp_g) begin
            n_err++; $display("FAIL b2b_grant_order got %0d grants want %0d (order 0,1,0,1)", g_seq.size(), exp_g.size());
        end
        n_cmp++; if (qdiff(q_out0, exp0) != 0) begin n_err++; $display("FAIL b2b_out0_data got %0d px want %0d", q_out0.size(), exp0.size()); end
        n_cmp++; if (qdiff(q_out1, exp1) != 0) begin n_err++; $display("FAIL b2b_out1_data got %0d px want %0d", q_out1.size(), exp1.size()); end
        n_cmp++; if (viol !== 0 || n_ab !== 0 || n_er !== 4) begin n_err++; $display("FAIL b2b_protocol got viol=%0d abort=%0d engrst=%0d want 0/0/4", viol, n_ab, n_er); end
    endtask

    task automatic test_drain();
        logic [7:0] want[$];
        int pop_at_fd1 = -1;
        clear_model();
        load(0, 2 * FP);
        for (int i = 0; i < 10; i++) want.push_back(exp0[i]);
        for (int i = FP; i < 2 * FP; i++) want.push_back(exp0[i]);
        e_target = 10;
        refresh();
        for (int i = 0; i < 400 && n_fd < 2; i++) begin
            step();
            if (n_fd == 1 && pop_at_fd1 < 0) begin pop_at_fd1 = pop0; e_target = FP; refresh(); end
        end
        n_cmp++; if (n_fd !== 2) begin n_err++; $display("FAIL drain_frame_done got %0d want 2", n_fd); end
        n_cmp++; if (pop_at_fd1 !== FP) begin n_err++; $display("FAIL drain_first_frame_reads got %0d want %0d", pop_at_fd1, FP); end
        n_cmp++; if (qdiff(q_out0, want) != 0) begin n_err++; $display("FAIL drain_out0_data got %0d px want %0d", q_out0.size(), want.size()); end
        n_cmp++; if (q_in0.size() !== 0 || viol !== 0) begin n_err++; $display("FAIL drain_leftover got in0=%0d viol=%0d want 0/0", q_in0.size(), viol); end
    endtask

    task automatic test_watchdog();
        int sz;
        logic [7:0] pre[$];
        do_reset();
        load(0, FP);
        for (int i = 0; i < 100 && q_out0.size() < 4; i++) step();
        out0_full = 1;
        sz = q_out0.size();
        for (int i = 0; i < 20 && n_ab == 0; i++) step();
        n_cmp++; if (n_ab !== 1) begin n_err++; $display("FAIL wdog_abort_pulse got %0d want 1", n_ab); end
        n_cmp++; if (ab_cyc - last_hs !== TO + 1) begin n_err++; $display("FAIL wdog_latency got %0d want %0d", ab_cyc - last_hs, TO + 1); end
        n_cmp++;
        if ({eng_reset, eng_empty, eng_full, fdone, abrt, in0_rd, out0_wr} !== 7'b0110000) begin
            n_err++; $display("FAIL wdog_back_to_idle got %b want 0110000", {eng_reset, eng_empty, eng_full, fdone, abrt, in0_rd, out0_wr});
        end
        n_cmp++; if (q_out0.size() !== sz || n_er !== 2 || viol !== 0) begin n_err++; $display("FAIL wdog_no_write got writes=%0d engrst=%0d viol=%0d want %0d/2/0", q_out0.size(), n_er, viol, sz); end
        for (int i = 0; i < sz; i++) pre.push_back(exp0[i]);
        n_cmp++; if (qdiff(q_out0, pre) != 0 || n_fd !== 0) begin n_err++; $display("FAIL wdog_prefix got diffs=%0d done=%0d want 0/0", qdiff(q_out0, pre), n_fd); end
        out0_full = 0;
        do_reset();
    endtask

    task automatic test_mid_reset();
        clear_model();
        load(0, FP);
        for (int i = 0; i < 100 && pop0 < 5; i++) step();
        rst = 1;
        step();
        n_cmp++;
        if ({grant, fdone, abrt, eng_reset, eng_empty, eng_full, in0_rd, in1_rd, out0_wr, out1_wr} !== 10'b1001110000) begin
            n_err++; $display("FAIL midreset_outputs got %b want 1001110000",
                              {grant, fdone, abrt, eng_reset, eng_empty, eng_full, in0_rd, in1_rd, out0_wr, out1_wr});
        end
        step();
        n_cmp++; if (eng_reset !== 1'b1 || pop0 < 5) begin n_err++; $display("FAIL midreset_eng_reset got %b reads=%0d want 1 and >=5", eng_reset, pop0); end
        clear_model();
        rst = 0;
    endtask

    task automatic test_saturate();
        logic [7:0] want[$];
        clear_model();
        load(0, FP + 4);
        for (int i = 0; i < FP; i++) want.push_back(exp0[i]);
        e_extra = 1;
        refresh();
        for (int i = 0; i < 200 && n_fd == 0; i++) step();
        rst = 1;
        n_cmp++; if (n_fd !== 1) begin n_err++; $display("FAIL sat_frame_done got %0d want 1", n_fd); end
        n_cmp++; if (pop0 !== FP || q_in0.size() !== 4) begin n_err++; $display("FAIL sat_reads got %0d left=%0d want %0d/4", pop0, q_in0.size(), FP); end
        n_cmp++; if (qdiff(q_out0, want) != 0 || viol !== 0) begin n_err++; $display("FAIL sat_writes got %0d px viol=%0d want %0d/0", q_out0.size(), viol, FP); end
        step(); step();
        clear_model();
        rst = 0;
    endtask

    initial begin
        cyc = 0;
        clear_model();
        test_reset();
        test_single();
        test_back_to_back();
        test_drain();
        test_watchdog();
        test_mid_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
